// File: rtl/hack_uart_tx.sv
// hack_uart_tx: 8N1 UART transmitter with a 4-entry byte FIFO for the Hack memory-mapped bus.
module hack_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       WR_EN,
  input  logic [7:0] WR_DATA,
  output logic       READY,
  output logic       TXD,
  output logic       BUSY,
  output logic [2:0] COUNT
);

  localparam int unsigned TIMER_W = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned PTR_W   = 2;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned BIT_W   = 3;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(7);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [TIMER_W-1:0]   timer;
  logic [TIMER_W-1:0]   timer_nxt;
  logic [BIT_W-1:0]     bit_idx;
  logic [BIT_W-1:0]     bit_idx_nxt;
  logic [7:0]           shift;
  logic [7:0]           shift_nxt;
  logic                 txd_nxt;

  logic [7:0]           mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count_nxt;

  logic                 push_c;
  logic                 pop_c;
  logic                 bit_done_c;
  logic                 fifo_nonempty_c;

  // Write acceptance uses the registered READY from before the edge, so a full FIFO drops the write.
  always_comb begin
    push_c          = WR_EN & READY;
    bit_done_c      = (timer == TIMER_LAST);
    fifo_nonempty_c = (COUNT != CNT_W'(0));
    count_nxt       = COUNT + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // Frame sequencer: next state, bit timer, shift register and next TXD level.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    txd_nxt     = TXD;
    pop_c       = 1'b0;

    case (state)
      IDLE: begin
        txd_nxt   = 1'b1;
        timer_nxt = '0;
        if (fifo_nonempty_c) begin
          pop_c     = 1'b1;
          shift_nxt = mem[rd_ptr];
          state_nxt = START;
          txd_nxt   = 1'b0;
        end
      end

      START: begin
        if (bit_done_c) begin
          timer_nxt   = '0;
          bit_idx_nxt = '0;
          state_nxt   = DATA;
          txd_nxt     = shift[0];
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end

      DATA: begin
        if (bit_done_c) begin
          timer_nxt = '0;
          if (bit_idx == BIT_LAST) begin
            state_nxt = STOP;
            txd_nxt   = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + BIT_W'(1);
            shift_nxt   = {1'b0, shift[7:1]};
            txd_nxt     = shift[1];
          end
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end

      STOP: begin
        if (bit_done_c) begin
          timer_nxt = '0;
          if (fifo_nonempty_c) begin
            // Chain straight into the next frame with no idle gap.
            pop_c     = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
            txd_nxt   = 1'b0;
          end else begin
            state_nxt = IDLE;
            txd_nxt   = 1'b1;
          end
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        txd_nxt   = 1'b1;
        timer_nxt = '0;
      end
    endcase
  end

  // State, timing, FIFO control and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      TXD     <= 1'b1;
      BUSY    <= 1'b0;
      COUNT   <= '0;
      READY   <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      TXD     <= txd_nxt;
      BUSY    <= (state_nxt != IDLE);
      COUNT   <= count_nxt;
      READY   <= (count_nxt != CNT_W'(DEPTH));
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // FIFO storage; contents are not cleared by reset.
  always_ff @(posedge CLK) begin
    if (RST_N && push_c) mem[wr_ptr] <= WR_DATA;
  end

endmodule

// File: tb/tb_hack_uart_tx.sv
// tb_hack_uart_tx: scoreboard bench for hack_uart_tx with CLKS_PER_BIT=4.
module tb_hack_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int          FRAME = 10 * CPB;

  logic       CLK;
  logic       RST_N;
  logic       WR_EN;
  logic [7:0] WR_DATA;
  logic       READY;
  logic       TXD;
  logic       BUSY;
  logic [2:0] COUNT;

  int         n_cmp;
  int         n_err;
  int         cyc;
  logic [7:0] sb [$];
  int         starts [$];

  hack_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .WR_EN   (WR_EN),
    .WR_DATA (WR_DATA),
    .READY   (READY),
    .TXD     (TXD),
    .BUSY    (BUSY),
    .COUNT   (COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cycle counter and scoreboard push on every accepted write; reset discards queued bytes.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RST_N !== 1'b1) sb.delete();
    else if (WR_EN === 1'b1 && READY === 1'b1) sb.push_back(WR_DATA);
  end

  // UART receiver: samples every cycle of each bit, checks level stability, framing and payload.
  logic [9:0] rx_bits;
  logic       rx_stable;
  logic       rx_abort;
  logic       rx_v;
  int         rx_t0;
  initial begin : uart_mon
    forever begin
      @(negedge CLK);
      if (RST_N === 1'b1 && TXD === 1'b0) begin
        rx_t0     = cyc;
        rx_stable = 1'b1;
        rx_abort  = 1'b0;
        rx_v      = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int s = 0; s < int'(CPB); s++) begin
            if (!(b == 0 && s == 0)) @(negedge CLK);
            if (RST_N !== 1'b1) rx_abort = 1'b1;
            if (s == 0) rx_v = TXD;
            else if (TXD !== rx_v) rx_stable = 1'b0;
          end
          rx_bits[b] = rx_v;
        end
        if (!rx_abort) begin
          starts.push_back(rx_t0);
          chk("rx_start_bit", 32'(rx_bits[0]), 32'd0);
          chk("rx_stop_bit", 32'(rx_bits[9]), 32'd1);
          chk("rx_bit_timing", 32'(rx_stable), 32'd1);
          chk("rx_frame_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) chk("rx_byte", 32'(rx_bits[8:1]), 32'(sb.pop_front()));
        end
      end
    end
  end

  // Bounded wait for the transmitter to drain and go idle.
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(BUSY === 1'b0 && COUNT === 3'd0 && TXD === 1'b1) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk("idle_reached", 32'(n < budget), 32'd1);
    repeat (2) @(negedge CLK);
  endtask

  // Five consecutive writes from idle, checking COUNT/READY after each edge.
  task automatic burst(input logic [7:0] base);
    int exp_cnt [5];
    int exp_rdy [5];
    exp_cnt = '{1, 1, 2, 3, 4};
    exp_rdy = '{1, 1, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (i > 0) begin
        chk("burst_count", 32'(COUNT), 32'(exp_cnt[i-1]));
        chk("burst_ready", 32'(READY), 32'(exp_rdy[i-1]));
      end
      WR_EN   = 1'b1;
      WR_DATA = base + 8'(i);
    end
    @(negedge CLK);
    WR_EN = 1'b0;
    chk("burst_count_peak", 32'(COUNT), 32'(exp_cnt[4]));
    chk("burst_ready_full", 32'(READY), 32'(exp_rdy[4]));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int e2;
  int busy_n;
  int low_n;

  initial begin : main
    n_cmp   = 0;
    n_err   = 0;
    cyc     = 0;
    RST_N   = 1'b0;
    WR_EN   = 1'b0;
    WR_DATA = 8'h00;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_txd", 32'(TXD), 32'd1);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_count", 32'(COUNT), 32'd0);
    chk("rst_ready", 32'(READY), 32'd1);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Single byte 0x55: one-edge latency, 40 busy cycles
    WR_EN   = 1'b1;
    WR_DATA = 8'h55;
    @(negedge CLK);
    WR_EN = 1'b0;
    chk("single_count1", 32'(COUNT), 32'd1);
    chk("single_busy_pre", 32'(BUSY), 32'd0);
    chk("single_txd_pre", 32'(TXD), 32'd1);
    @(negedge CLK);
    chk("single_latency_txd", 32'(TXD), 32'd0);
    chk("single_busy", 32'(BUSY), 32'd1);
    chk("single_count0", 32'(COUNT), 32'd0);
    busy_n = 1;
    repeat (59) begin
      @(negedge CLK);
      if (BUSY === 1'b1) busy_n++;
    end
    chk("single_busy_cycles", 32'(busy_n), 32'(FRAME));
    chk("single_txd_end", 32'(TXD), 32'd1);
    chk("single_busy_end", 32'(BUSY), 32'd0);
    wait_idle(200);

    // Burst of five: all accepted, frames back-to-back
    starts.delete();
    burst(8'h01);
    wait_idle(400);
    chk("burst_frames", 32'(starts.size()), 32'd5);
    for (int i = 0; i + 1 < starts.size(); i++)
      chk("burst_spacing", 32'(starts[i+1] - starts[i]), 32'(FRAME));

    // Overflow: 0xAA held while full must never be accepted
    burst(8'h21);
    WR_EN   = 1'b1;
    WR_DATA = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("ovf_count", 32'(COUNT), 32'd4);
      chk("ovf_ready", 32'(READY), 32'd0);
    end
    WR_EN = 1'b0;
    wait_idle(400);

    // Same-edge write and pop on the final STOP edge
    @(negedge CLK);
    e2      = cyc + 2;
    WR_EN   = 1'b1;
    WR_DATA = 8'hA0;
    @(negedge CLK);
    WR_DATA = 8'hA1;
    @(negedge CLK);
    WR_DATA = 8'hA2;
    @(negedge CLK);
    WR_EN = 1'b0;
    chk("se_count_pre", 32'(COUNT), 32'd2);
    while (cyc < e2 + FRAME - 1) @(negedge CLK);
    chk("se_stop_level", 32'(TXD), 32'd1);
    chk("se_count_before", 32'(COUNT), 32'd2);
    WR_EN   = 1'b1;
    WR_DATA = 8'hA3;
    @(negedge CLK);
    WR_EN = 1'b0;
    chk("se_count_after", 32'(COUNT), 32'd2);
    chk("se_busy", 32'(BUSY), 32'd1);
    chk("se_restart_txd", 32'(TXD), 32'd0);
    wait_idle(400);

    // Reset during data bit 3 of 0xF0 with two bytes queued
    @(negedge CLK);
    e2      = cyc + 2;
    WR_EN   = 1'b1;
    WR_DATA = 8'hF0;
    @(negedge CLK);
    WR_DATA = 8'hB1;
    @(negedge CLK);
    WR_DATA = 8'hB2;
    @(negedge CLK);
    WR_EN = 1'b0;
    while (cyc < e2 + 4 * int'(CPB)) @(negedge CLK);
    chk("rst_mid_bit3", 32'(TXD), 32'd0);
    chk("rst_mid_count", 32'(COUNT), 32'd2);
    RST_N   = 1'b0;
    WR_EN   = 1'b1;
    WR_DATA = 8'h77;
    @(negedge CLK);
    chk("rst_mid_txd", 32'(TXD), 32'd1);
    chk("rst_mid_busy", 32'(BUSY), 32'd0);
    chk("rst_mid_count0", 32'(COUNT), 32'd0);
    chk("rst_mid_ready", 32'(READY), 32'd1);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    WR_EN = 1'b0;
    busy_n = 0;
    low_n  = 0;
    repeat (100) begin
      @(negedge CLK);
      if (BUSY !== 1'b0) busy_n++;
      if (TXD !== 1'b1) low_n++;
    end
    chk("rst_mid_no_busy", 32'(busy_n), 32'd0);
    chk("rst_mid_no_frames", 32'(low_n), 32'd0);

    // Random write stress; dense then sparse traffic
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      if (i < 1000) WR_EN = ($urandom_range(0, 9) < 3);
      else          WR_EN = ($urandom_range(0, 19) == 0);
      WR_DATA = 8'($urandom);
    end
    @(negedge CLK);
    WR_EN = 1'b0;
    wait_idle(600);
    chk("stress_sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
